// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state, phase and bus-level constants for the I2C master
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_WR,
    ST_ACK_W,
    ST_RD,
    ST_MACK,
    ST_STOP
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - quarter-SCL-period tick divider, held at zero when disabled
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic qtick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - clocked I2C master: START, address, multi-byte write/read, STOP
module i2c_master_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [CNT_W-1:0] nbytes,
  input  logic [7:0]       wdata,
  output logic             wdata_next,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_i
);
  import i2c_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state, state_n;
  qphase_t          q, q_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [CNT_W-1:0] byte_cnt, byte_n;
  logic [7:0]       shifter, shift_n, rdata_n;
  logic             ack_bit, ack_bit_n, rw_q, rw_n, err_n;
  logic             busy_n, done_n, wnext_n, rvalid_n, scl_n, sda_n, load_wr;
  logic [1:0]       sda_sync;
  logic             sda_s, qtick;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .qtick (qtick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sda_sync <= 2'b11;
    else      sda_sync <= {sda_sync[0], sda_i};
  end
  assign sda_s = sda_sync[1];

  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    shift_n   = shifter;
    ack_bit_n = ack_bit;
    rw_n      = rw_q;
    err_n     = ack_err;
    rdata_n   = rdata;
    busy_n    = busy;
    done_n    = 1'b0;
    wnext_n   = 1'b0;
    rvalid_n  = 1'b0;
    load_wr   = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        state_n = ST_START;
        q_n     = Q0;
        rw_n    = rw;
        byte_n  = (nbytes > MAX_CNT) ? MAX_CNT : nbytes;
        shift_n = {addr, rw};
        bit_n   = 3'd7;
        err_n   = 1'b0;
        busy_n  = 1'b1;
      end
    end else if (qtick) begin
      q_n = qphase_t'(q + 2'd1);
      if (q == Q2 && (state == ST_ACK_A || state == ST_ACK_W)) ack_bit_n = sda_s;
      if (q == Q2 && state == ST_RD) shift_n = {shifter[6:0], sda_s};
      unique case (state)
        ST_START: if (q == Q1) begin
          state_n = ST_ADDR;
          q_n     = Q0;
        end
        ST_ADDR, ST_WR: if (q == Q3) begin
          if (bit_cnt == 3'd0) state_n = (state == ST_ADDR) ? ST_ACK_A : ST_ACK_W;
          else begin
            shift_n = {shifter[6:0], 1'b0};
            bit_n   = bit_cnt - 3'd1;
          end
        end
        ST_ACK_A: if (q == Q3) begin
          if (ack_bit == NACK) begin
            err_n   = 1'b1;
            state_n = ST_STOP;
          end else if (byte_cnt == '0) state_n = ST_STOP;
          else if (rw_q == RW_WRITE) load_wr = 1'b1;
          else begin
            state_n = ST_RD;
            bit_n   = 3'd7;
          end
        end
        ST_ACK_W: if (q == Q3) begin
          if (ack_bit == ACK) begin
            byte_n = byte_cnt - CNT_W'(1);
            if (byte_cnt == CNT_W'(1)) state_n = ST_STOP;
            else                       load_wr = 1'b1;
          end else begin
            err_n   = 1'b1;
            state_n = ST_STOP;
          end
        end
        ST_RD: if (q == Q3) begin
          if (bit_cnt == 3'd0) begin
            state_n  = ST_MACK;
            rdata_n  = shifter;
            rvalid_n = 1'b1;
          end else bit_n = bit_cnt - 3'd1;
        end
        ST_MACK: if (q == Q3) begin
          byte_n = byte_cnt - CNT_W'(1);
          if (byte_cnt == CNT_W'(1)) state_n = ST_STOP;
          else begin
            state_n = ST_RD;
            bit_n   = 3'd7;
          end
        end
        ST_STOP: if (q == Q3) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if (load_wr) begin
      state_n = ST_WR;
      bit_n   = 3'd7;
      shift_n = wdata;
      wnext_n = 1'b1;
    end
    // Pad drives are decoded from the next state so they leave a flop cleanly.
    scl_n = 1'b0;
    sda_n = 1'b0;
    case (state_n)
      ST_IDLE:  sda_n = 1'b0;
      ST_START: sda_n = 1'b1;
      ST_STOP: begin
        scl_n = (q_n == Q0);
        sda_n = (q_n == Q0) || (q_n == Q1);
      end
      default: begin
        scl_n = (q_n == Q0) || (q_n == Q3);
        if (state_n == ST_ADDR || state_n == ST_WR) sda_n = ~shift_n[7];
        else if (state_n == ST_MACK)                sda_n = (byte_n != CNT_W'(1));
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      q           <= Q0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shifter     <= '0;
      ack_bit     <= 1'b0;
      rw_q        <= 1'b0;
      ack_err     <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_next  <= 1'b0;
      rdata_valid <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
    end else begin
      state       <= state_n;
      q           <= q_n;
      bit_cnt     <= bit_n;
      byte_cnt    <= byte_n;
      shifter     <= shift_n;
      ack_bit     <= ack_bit_n;
      rw_q        <= rw_n;
      ack_err     <= err_n;
      rdata       <= rdata_n;
      busy        <= busy_n;
      done        <= done_n;
      wdata_next  <= wnext_n;
      rdata_valid <= rvalid_n;
      scl_oe      <= scl_n;
      sda_oe      <= sda_n;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench with protocol-level slave and transaction model
module tb_i2c_master_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 16;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0]       addr = '0;
  logic [CNT_W-1:0] nbytes = '0;
  logic [7:0]       wdata = '0;
  logic             wdata_next, rdata_valid, busy, done, ack_err, scl_oe, sda_oe, sda_i;
  logic [7:0]       rdata;
  logic             sl_drv = 1'b0;

  assign sda_i = ~(sda_oe | sl_drv);
  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .nbytes(nbytes),
    .wdata(wdata), .wdata_next(wdata_next), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_i(sda_i)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave configuration, host data and bus observations
  bit         cfg_addr_ack;
  int         cfg_nack_at;
  logic [7:0] wb [16];
  logic [7:0] rb [16];
  logic [8:0] bus_q [$];
  int         n_start = 0, n_stop = 0;

  logic       scl_b, sda_b, scl_p = 1'b1, sda_p = 1'b1;
  bit         active = 0, rwbit = 0, last_ack = 1;
  int         bitpos = 0, frame = 0;
  logic [7:0] shreg = '0;

  function automatic logic slave_bit(input int fr, input int b);
    if (fr == 0) return (b == 8) ? cfg_addr_ack : 1'b0;
    if (!rwbit) return (b == 8) ? 1'(fr - 1 != cfg_nack_at) : 1'b0;
    if (b == 8 || last_ack || fr > 16) return 1'b0;
    return ~rb[fr-1][7-b];
  endfunction

  // Slave: START/STOP detection, samples on SCL rise, changes SDA on SCL fall
  always @(negedge clk) begin
    scl_b = ~scl_oe;
    sda_b = sda_i;
    if (!rst) begin
      sl_drv = 1'b0; active = 0; bitpos = 0; frame = 0;
    end else if (scl_b && scl_p && sda_p && !sda_b) begin
      n_start++; active = 1; bitpos = 0; frame = 0; sl_drv = 1'b0; last_ack = 1;
    end else if (scl_b && scl_p && !sda_p && sda_b) begin
      n_stop++; active = 0; sl_drv = 1'b0;
    end else if (active && scl_b && !scl_p) begin
      if (bitpos < 8) shreg = {shreg[6:0], sda_b};
      else begin
        bus_q.push_back({shreg, sda_b});
        if (frame == 0) rwbit = shreg[0];
        last_ack = sda_b;
      end
      bitpos++;
    end else if (active && !scl_b && scl_p) begin
      if (bitpos == 9) begin
        bitpos = 0;
        frame++;
      end
      sl_drv = slave_bit(frame, bitpos);
    end
    scl_p = scl_b;
    sda_p = sda_b;
  end

  // Transaction-level reference: expected bus frames {byte, ack bit} and host-side results
  logic [8:0] exp_q [$];
  logic [7:0] exp_rd [$];
  int         m_err, m_wnext, m_busy;

  task automatic model(input logic r, input logic [6:0] a, input int n, input bit aack, input int nack);
    int neff;
    neff = (n > MAX_BYTES) ? MAX_BYTES : n;
    exp_q.delete();
    exp_rd.delete();
    m_wnext = 0;
    m_err   = aack ? 0 : 1;
    exp_q.push_back({a, r, 1'(!aack)});
    if (aack) begin
      for (int i = 0; i < neff; i++) begin
        if (!r) begin
          m_wnext++;
          exp_q.push_back({wb[i], 1'(i == nack)});
          if (i == nack) begin
            m_err = 1;
            break;
          end
        end else begin
          exp_q.push_back({rb[i], 1'(i == neff - 1)});
          exp_rd.push_back(rb[i]);
        end
      end
    end
    m_busy = (6 + 36 * exp_q.size()) * CLK_DIV;
  endtask

  task automatic run_txn(input logic r, input logic [6:0] a, input int n, input bit aack,
                         input int nack, input bit overlap, input int e_err, input int e_wnext,
                         input int e_busy, input string tag);
    int         wn, bc, dn, cyc;
    logic [7:0] rd_q [$];
    wn = 0; bc = 0; dn = 0; cyc = 0;
    model(r, a, n, aack, nack);
    cfg_addr_ack = aack;
    cfg_nack_at  = nack;
    bus_q.delete();
    n_start = 0;
    n_stop  = 0;
    @(negedge clk);
    rw = r; addr = a; nbytes = CNT_W'(n); wdata = wb[0]; start = 1'b1;
    while (dn == 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (overlap && cyc == 40) begin
        start = 1'b1; addr = 7'h55; rw = ~r; nbytes = CNT_W'(3);
      end
      if (busy) bc++;
      if (wdata_next) begin
        wn++;
        wdata = (wn < 16) ? wb[wn] : 8'h00;
      end
      if (rdata_valid) rd_q.push_back(rdata);
      if (done) begin
        dn++;
        chk({tag, " busy_at_done"}, busy, 0);
      end
    end
    if (dn == 0) chk({tag, " timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, " done_width"}, done, 0);
    chk({tag, " ack_err"}, ack_err, e_err);
    chk({tag, " wdata_next_cnt"}, wn, e_wnext);
    chk({tag, " busy_cycles"}, bc, e_busy);
    chk({tag, " starts"}, n_start, 1);
    chk({tag, " stops"}, n_stop, 1);
    chk({tag, " frames"}, bus_q.size(), exp_q.size());
    for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s frame%0d", tag, i), bus_q[i], exp_q[i]);
    chk({tag, " rd_cnt"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      chk($sformatf("%s rdata%0d", tag, i), rd_q[i], exp_rd[i]);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    int         nbytes;
    bit         aack;
    int         nack_at;
    bit         overlap;
    logic [7:0] b0, b1, b2;
    int         e_err, e_wnext, e_busy;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  task automatic load_data(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 16; i++) begin
      wb[i] = 8'(8'h60 + i);
      rb[i] = 8'(8'h90 + 3 * i);
    end
    wb[0] = b0; wb[1] = b1; wb[2] = b2;
    rb[0] = b0; rb[1] = b1; rb[2] = b2;
  endtask

  initial begin
    vt[0] = '{1'b0, 7'h27, 2,  1'b1, 99, 1'b0, 8'h18, 8'hA5, 8'h00, 0, 2,  456};
    vt[1] = '{1'b1, 7'h27, 3,  1'b1, 99, 1'b0, 8'h11, 8'h22, 8'h33, 0, 0,  600};
    vt[2] = '{1'b0, 7'h27, 4,  1'b0, 99, 1'b0, 8'h01, 8'h02, 8'h03, 1, 0,  168};
    vt[3] = '{1'b0, 7'h27, 3,  1'b1, 0,  1'b0, 8'h18, 8'hA5, 8'h3C, 1, 1,  312};
    vt[4] = '{1'b0, 7'h27, 0,  1'b1, 99, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0,  168};
    vt[5] = '{1'b0, 7'h3A, 2,  1'b1, 99, 1'b1, 8'hC3, 8'h5A, 8'h00, 0, 2,  456};
    vt[6] = '{1'b0, 7'h27, 31, 1'b1, 99, 1'b0, 8'hF0, 8'h0F, 8'h81, 0, 16, 2472};
    vt[7] = '{1'b1, 7'h12, 31, 1'b1, 99, 1'b0, 8'hFF, 8'h00, 8'h7E, 0, 0,  2472};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset scl_oe", scl_oe, 0);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ack_err", ack_err, 0);
    chk("reset rdata", rdata, 0);
    chk("reset wdata_next", wdata_next, 0);
    chk("reset rdata_valid", rdata_valid, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      load_data(vt[k].b0, vt[k].b1, vt[k].b2);
      run_txn(vt[k].rw, vt[k].addr, vt[k].nbytes, vt[k].aack, vt[k].nack_at, vt[k].overlap,
              vt[k].e_err, vt[k].e_wnext, vt[k].e_busy, $sformatf("vec%0d", k));
    end

    // Reset asserted in the middle of a write must release the bus at once
    load_data(8'h18, 8'hA5, 8'h77);
    cfg_addr_ack = 1'b1;
    cfg_nack_at  = 99;
    @(negedge clk);
    rw = 1'b0; addr = 7'h27; nbytes = CNT_W'(4); wdata = wb[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    chk("midwrite busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("rst_async scl_oe", scl_oe, 0);
    chk("rst_async sda_oe", sda_oe, 0);
    chk("rst_async busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    load_data(vt[0].b0, vt[0].b1, vt[0].b2);
    run_txn(vt[0].rw, vt[0].addr, vt[0].nbytes, vt[0].aack, vt[0].nack_at, 1'b0,
            vt[0].e_err, vt[0].e_wnext, vt[0].e_busy, "after_reset");

    for (int k = 0; k < 10; k++) begin
      logic       r;
      logic [6:0] a;
      int         n, nack;
      bit         aack;
      r    = 1'($urandom_range(0, 1));
      a    = 7'($urandom_range(0, 127));
      n    = $urandom_range(0, 20);
      aack = ($urandom_range(0, 3) != 0);
      nack = $urandom_range(0, 24);
      for (int i = 0; i < 16; i++) begin
        wb[i] = 8'($urandom_range(0, 255));
        rb[i] = 8'($urandom_range(0, 255));
      end
      model(r, a, n, aack, nack);
      run_txn(r, a, n, aack, nack, 1'b0, m_err, m_wnext, m_busy, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
